// File: rtl/dvi_pkg.sv
// Shared constants for the DVI raster timing controller: register map,
// 640x480@60 default timing and pixel component width.
package dvi_pkg;

  localparam logic [2:0] REG_H_ACTIVE     = 3'd0;
  localparam logic [2:0] REG_H_SYNC_START = 3'd1;
  localparam logic [2:0] REG_H_SYNC_END   = 3'd2;
  localparam logic [2:0] REG_H_TOTAL      = 3'd3;
  localparam logic [2:0] REG_V_ACTIVE     = 3'd4;
  localparam logic [2:0] REG_V_SYNC_START = 3'd5;
  localparam logic [2:0] REG_V_SYNC_END   = 3'd6;
  localparam logic [2:0] REG_V_TOTAL      = 3'd7;
  localparam int         NUM_REGS         = 8;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_SYNC_START = 656;
  localparam int DEF_H_SYNC_END   = 752;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_SYNC_START = 490;
  localparam int DEF_V_SYNC_END   = 492;
  localparam int DEF_V_TOTAL      = 525;

  localparam int RGB_W = 8;

endpackage

// File: rtl/dvi_timing_counter.sv
// One raster axis: wrapping position counter plus active-area and sync-window
// decodes of the current position.
module dvi_timing_counter #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [CW-1:0] i_active,
  input  logic [CW-1:0] i_sync_start,
  input  logic [CW-1:0] i_sync_end,
  input  logic [CW-1:0] i_total,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_active,
  output logic          o_sync
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  // A total of zero is treated as a one-position axis.
  assign w_last   = (i_total == '0) ? '0 : i_total - CW'(1);
  assign o_wrap   = (r_cnt >= w_last);
  assign o_active = (r_cnt < i_active);
  assign o_sync   = (r_cnt >= i_sync_start) && (r_cnt < i_sync_end);
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing controller: programmable h/v timing with frame-boundary
// shadow loading, pixel handshake and registered TMDS-side outputs.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int CW               = 12,
  parameter int RST_H_ACTIVE     = DEF_H_ACTIVE,
  parameter int RST_H_SYNC_START = DEF_H_SYNC_START,
  parameter int RST_H_SYNC_END   = DEF_H_SYNC_END,
  parameter int RST_H_TOTAL      = DEF_H_TOTAL,
  parameter int RST_V_ACTIVE     = DEF_V_ACTIVE,
  parameter int RST_V_SYNC_START = DEF_V_SYNC_START,
  parameter int RST_V_SYNC_END   = DEF_V_SYNC_END,
  parameter int RST_V_TOTAL      = DEF_V_TOTAL
) (
  input  logic               pixclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [CW-1:0]      cfg_wdata,
  input  logic               pix_valid,
  input  logic [3*RGB_W-1:0] pix_data,
  output logic               pix_ready,
  input  logic               underflow_clr,
  output logic [RGB_W-1:0]   red,
  output logic [RGB_W-1:0]   green,
  output logic [RGB_W-1:0]   blue,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start,
  output logic               underflow
);

  logic [CW-1:0] w_active [NUM_REGS];
  logic [CW-1:0] w_x, w_y;
  logic          w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_h_sync, w_v_sync;
  logic          w_load, w_in_area;

  // Loading while disabled lets software retime an idle raster immediately.
  assign w_load = !enable || (w_h_wrap && w_v_wrap);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam int RV =
      (gi == int'(REG_H_ACTIVE))     ? RST_H_ACTIVE     :
      (gi == int'(REG_H_SYNC_START)) ? RST_H_SYNC_START :
      (gi == int'(REG_H_SYNC_END))   ? RST_H_SYNC_END   :
      (gi == int'(REG_H_TOTAL))      ? RST_H_TOTAL      :
      (gi == int'(REG_V_ACTIVE))     ? RST_V_ACTIVE     :
      (gi == int'(REG_V_SYNC_START)) ? RST_V_SYNC_START :
      (gi == int'(REG_V_SYNC_END))   ? RST_V_SYNC_END   : RST_V_TOTAL;

    logic [CW-1:0] r_shadow, r_active, w_shadow_next;

    // Forwarding the write lets a frame-end write land in that same load.
    assign w_shadow_next = (cfg_we && cfg_addr == 3'(gi)) ? cfg_wdata : r_shadow;
    assign w_active[gi]  = r_active;

    always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= CW'(RV);
        r_active <= CW'(RV);
      end else begin
        r_shadow <= w_shadow_next;
        if (w_load) r_active <= w_shadow_next;
      end
    end
  end

  dvi_timing_counter #(.CW(CW)) u_h_cnt (
    .clk          (pixclk),
    .rst_n        (rst_n),
    .i_clr        (!enable),
    .i_adv        (1'b1),
    .i_active     (w_active[REG_H_ACTIVE]),
    .i_sync_start (w_active[REG_H_SYNC_START]),
    .i_sync_end   (w_active[REG_H_SYNC_END]),
    .i_total      (w_active[REG_H_TOTAL]),
    .o_cnt        (w_x),
    .o_wrap       (w_h_wrap),
    .o_active     (w_h_act),
    .o_sync       (w_h_sync)
  );

  dvi_timing_counter #(.CW(CW)) u_v_cnt (
    .clk          (pixclk),
    .rst_n        (rst_n),
    .i_clr        (!enable),
    .i_adv        (w_h_wrap),
    .i_active     (w_active[REG_V_ACTIVE]),
    .i_sync_start (w_active[REG_V_SYNC_START]),
    .i_sync_end   (w_active[REG_V_SYNC_END]),
    .i_total      (w_active[REG_V_TOTAL]),
    .o_cnt        (w_y),
    .o_wrap       (w_v_wrap),
    .o_active     (w_v_act),
    .o_sync       (w_v_sync)
  );

  assign w_in_area = w_h_act && w_v_act;
  assign pix_ready = enable && w_in_area;

  logic [3*RGB_W-1:0] r_rgb;
  logic               r_hsync, r_vsync, r_de, r_frame_start, r_underflow;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_rgb         <= (pix_ready && pix_valid) ? pix_data : '0;
      r_hsync       <= enable && w_h_sync;
      r_vsync       <= enable && w_v_sync;
      r_de          <= pix_ready;
      r_frame_start <= enable && (w_x == '0) && (w_y == '0);
      r_underflow   <= (pix_ready && !pix_valid) || (r_underflow && !underflow_clr);
    end
  end

  assign {red, green, blue} = r_rgb;
  assign hsync              = r_hsync;
  assign vsync              = r_vsync;
  assign de                 = r_de;
  assign frame_start        = r_frame_start;
  assign underflow          = r_underflow;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl against a cycle-level raster model
// built from plain integer position arithmetic.
module tb_dvi_timing_ctrl;

  logic        pixclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_wdata;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        underflow_clr;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, frame_start, underflow;

  always #5 pixclk = ~pixclk;

  dvi_timing_ctrl dut (
    .pixclk        (pixclk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .underflow_clr (underflow_clr),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: raster position, shadow and live timing tables, sticky flag.
  int          mx, my;
  int          sh[8];
  int          ac[8];
  bit          m_uf;
  logic [3:0]  e_sync;
  logic [23:0] e_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t (x=%0d y=%0d)", tag, got, exp, $time, mx, my);
    end
  endtask

  function automatic void model_reset();
    sh   = '{640, 656, 752, 800, 480, 490, 492, 525};
    ac   = sh;
    mx   = 0;
    my   = 0;
    m_uf = 1'b0;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic tick();
    int ht, vt;
    bit act, fend;
    #1;
    ht  = (ac[3] == 0) ? 1 : ac[3];
    vt  = (ac[7] == 0) ? 1 : ac[7];
    act = enable && (mx < ac[0]) && (my < ac[4]);
    check("pix_ready", 32'(pix_ready), 32'(act));
    e_sync = {act,
              enable && (ac[1] <= mx) && (mx < ac[2]),
              enable && (ac[5] <= my) && (my < ac[6]),
              enable && (mx == 0) && (my == 0)};
    e_rgb  = (act && pix_valid) ? pix_data : 24'h0;
    if (act && !pix_valid) m_uf = 1'b1;
    else if (underflow_clr) m_uf = 1'b0;
    fend = (mx == ht - 1) && (my == vt - 1);
    if (cfg_we) sh[cfg_addr] = int'(cfg_wdata);
    if (!enable || fend) ac = sh;
    if (!enable) begin
      mx = 0;
      my = 0;
    end else if (mx == ht - 1) begin
      mx = 0;
      my = (my == vt - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    @(posedge pixclk);
    @(negedge pixclk);
    check("de_hs_vs_fs", 32'({de, hsync, vsync, frame_start}), 32'(e_sync));
    check("rgb", 32'({red, green, blue}), 32'(e_rgb));
    check("underflow", 32'(underflow), 32'(m_uf));
  endtask

  initial begin
    int ha, vb;
    rst_n         = 1'b0;
    enable        = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = 3'd0;
    cfg_wdata     = 12'd0;
    pix_valid     = 1'b0;
    pix_data      = 24'd0;
    underflow_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge pixclk);
    check("reset_outputs", 32'({de, hsync, vsync, frame_start, underflow, red, green, blue}), 32'd0);
    rst_n = 1'b1;

    // Default 640x480 timing, steady source with an x-derived pattern.
    enable    = 1'b1;
    pix_valid = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      pix_data      = {8'(mx), 8'(mx >> 1), 8'(my)};
      pix_valid     = (c != 100);
      underflow_clr = (c == 1200);
      tick();
    end

    // Small random timing loaded while disabled.
    enable = 1'b0;
    ha = $urandom_range(4, 20);
    vb = $urandom_range(3, 10);
    for (int r = 0; r < 8; r++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 3'(r);
      case (r)
        0: cfg_wdata = 12'(ha);
        1: cfg_wdata = 12'(ha + 2);
        2: cfg_wdata = 12'(ha + 5);
        3: cfg_wdata = 12'(ha + 8);
        4: cfg_wdata = 12'(vb);
        5: cfg_wdata = 12'(vb + 1);
        6: cfg_wdata = 12'(vb + 2);
        default: cfg_wdata = 12'(vb + 4);
      endcase
      tick();
    end
    cfg_we = 1'b0;

    // Random run: enable drops, source gaps, flag clears, mid-frame retiming.
    for (int c = 0; c < 40000; c++) begin
      enable        = ($urandom_range(0, 299) != 0);
      pix_valid     = ($urandom_range(0, 19) != 0);
      underflow_clr = ($urandom_range(0, 49) == 0);
      pix_data      = 24'($urandom);
      cfg_we        = ($urandom_range(0, 149) == 0);
      cfg_addr      = 3'($urandom_range(0, 7));
      cfg_wdata     = (cfg_addr[1:0] == 2'd3) ? 12'($urandom_range(0, 24))
                                              : 12'($urandom_range(0, 26));
      tick();
    end
    cfg_we = 1'b0;

    // Asynchronous reset mid-frame: outputs clear at once, defaults return.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({de, hsync, vsync, frame_start, underflow, red, green, blue}), 32'd0);
    model_reset();
    enable    = 1'b1;
    pix_valid = 1'b1;
    @(negedge pixclk);
    rst_n = 1'b1;
    for (int c = 0; c < 1700; c++) begin
      pix_data      = 24'($urandom);
      underflow_clr = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
